// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, synchronous-read data memory.
// Port 0 has fixed priority; a wait counter forces a port 1 grant after MAX_WAIT denials.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              forced_1
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam bit         GUARD_EN   = (MAX_WAIT != 0);

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              pend_vld_q, pend_vld_d;
    logic              pend_own_q, pend_own_d;
    logic              rvalid_0_q, rvalid_0_d;
    logic              rvalid_1_q, rvalid_1_d;
    logic [DATA_W-1:0] rdata_0_q, rdata_0_d;
    logic [DATA_W-1:0] rdata_1_q, rdata_1_d;

    logic              force_s;
    logic              gnt_0_s, gnt_1_s;
    logic              we_sel_s;

    // Arbitration and memory-side drive; grants are gated off while reset is asserted
    always_comb begin
        force_s   = 1'b0;
        gnt_0_s   = 1'b0;
        gnt_1_s   = 1'b0;
        if (GUARD_EN && (wait_cnt_q >= MAX_WAIT_C) && req_1) begin
            force_s = 1'b1;
        end else begin
            force_s = 1'b0;
        end
        if (!rst_n) begin
            gnt_0_s = 1'b0;
            gnt_1_s = 1'b0;
        end else if (force_s) begin
            gnt_1_s = 1'b1;
        end else if (req_0) begin
            gnt_0_s = 1'b1;
        end else if (req_1) begin
            gnt_1_s = 1'b1;
        end else begin
            gnt_0_s = 1'b0;
            gnt_1_s = 1'b0;
        end
        if (gnt_1_s) begin
            mem_addr  = addr_1;
            mem_wdata = wdata_1;
            we_sel_s  = we_1;
        end else begin
            mem_addr  = addr_0;
            mem_wdata = wdata_0;
            we_sel_s  = we_0;
        end
        mem_write = (gnt_0_s | gnt_1_s) & we_sel_s;
        mem_read  = (gnt_0_s | gnt_1_s) & ~we_sel_s;
        gnt_0     = gnt_0_s;
        gnt_1     = gnt_1_s;
        forced_1  = force_s & req_0 & rst_n;
    end

    // Next-state: starvation counter, read-owner pipeline stage and read return capture
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_1 || gnt_1_s) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        pend_vld_d = (gnt_0_s | gnt_1_s) & ~we_sel_s;
        pend_own_d = gnt_1_s;
        rvalid_0_d = pend_vld_q & ~pend_own_q;
        rvalid_1_d = pend_vld_q & pend_own_q;
        if (rvalid_0_d) begin
            rdata_0_d = mem_rdata;
        end else begin
            rdata_0_d = rdata_0_q;
        end
        if (rvalid_1_d) begin
            rdata_1_d = mem_rdata;
        end else begin
            rdata_1_d = rdata_1_q;
        end
    end

    // State registers; an in-flight read is dropped by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            pend_vld_q <= 1'b0;
            pend_own_q <= 1'b0;
            rvalid_0_q <= 1'b0;
            rvalid_1_q <= 1'b0;
            rdata_0_q  <= {DATA_W{1'b0}};
            rdata_1_q  <= {DATA_W{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_own_q <= pend_own_d;
            rvalid_0_q <= rvalid_0_d;
            rvalid_1_q <= rvalid_1_d;
            rdata_0_q  <= rdata_0_d;
            rdata_1_q  <= rdata_1_d;
        end
    end

    assign rvalid_0 = rvalid_0_q;
    assign rvalid_1 = rvalid_1_q;
    assign rdata_0  = rdata_0_q;
    assign rdata_1  = rdata_1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_0, we_0, req_1, we_1;
    logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
    logic        gnt_0, rvalid_0, gnt_1, rvalid_1;
    logic [31:0] rdata_0, rdata_1;
    logic        mem_read, mem_write, forced_1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        gnt_0z, rvalid_0z, gnt_1z, rvalid_1z, mem_readz, mem_writez, forced_1z;
    logic [31:0] rdata_0z, rdata_1z, mem_addrz, mem_wdataz;
    logic [31:0] zero_rdata = 32'd0;

    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .forced_1(forced_1)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(0)) u_dut_nowait (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0z), .rvalid_0(rvalid_0z), .rdata_0(rdata_0z),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1z), .rvalid_1(rvalid_1z), .rdata_1(rdata_1z),
        .mem_read(mem_readz), .mem_write(mem_writez), .mem_addr(mem_addrz),
        .mem_wdata(mem_wdataz), .mem_rdata(zero_rdata), .forced_1(forced_1z)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 3) ? 32'h0000_00AB : (32'h1000_0000 + 32'(i) * 32'h11);
    endfunction

    // Synchronous-read memory, preloaded while reset is held across a clock edge
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
            if (mem_read)  mem_rdata <= mem[mem_addr[3:0]];
        end
    end

    typedef struct {bit port; logic [31:0] data; int due;} rd_t;
    rd_t         exp_q[$];
    logic [31:0] ref_mem [0:15];
    logic [31:0] ref_rd0, ref_rd1;
    int          ref_wait, cyc;
    bit          g0, g1;
    int          n_chk, n_pass;
    int          n_forced, n_gnt1, z_gnt1, z_forced;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // One arbitration cycle: predict, compare at the falling edge, advance the model
    task automatic step();
        bit   f, eg0, eg1, erv0, erv1;
        rd_t  it;
        @(negedge clk);
        f   = (ref_wait >= MW) && (MW != 0) && req_1;
        eg1 = req_1 && (f || !req_0);
        eg0 = req_0 && !f;
        check_eq("gnt_0", 64'(gnt_0), 64'(eg0));
        check_eq("gnt_1", 64'(gnt_1), 64'(eg1));
        check_eq("forced_1", 64'(forced_1), 64'(f && req_0));
        check_eq("mem_read", 64'(mem_read), 64'((eg0 && !we_0) || (eg1 && !we_1)));
        check_eq("mem_write", 64'(mem_write), 64'((eg0 && we_0) || (eg1 && we_1)));
        if (eg0) check_eq("mem_addr0", 64'(mem_addr), 64'(addr_0));
        if (eg1) check_eq("mem_addr1", 64'(mem_addr), 64'(addr_1));
        if (eg0 && we_0) check_eq("mem_wdata0", 64'(mem_wdata), 64'(wdata_0));
        if (eg1 && we_1) check_eq("mem_wdata1", 64'(mem_wdata), 64'(wdata_1));
        erv0 = 1'b0;
        erv1 = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            it = exp_q.pop_front();
            if (it.port) begin erv1 = 1'b1; ref_rd1 = it.data; end
            else         begin erv0 = 1'b1; ref_rd0 = it.data; end
        end
        check_eq("rvalid_0", 64'(rvalid_0), 64'(erv0));
        check_eq("rvalid_1", 64'(rvalid_1), 64'(erv1));
        check_eq("rdata_0", 64'(rdata_0), 64'(ref_rd0));
        check_eq("rdata_1", 64'(rdata_1), 64'(ref_rd1));
        check_eq("nowait_gnt_0", 64'(gnt_0z), 64'(req_0));
        check_eq("nowait_gnt_1", 64'(gnt_1z), 64'(req_1 && !req_0));
        check_eq("nowait_forced", 64'(forced_1z), 64'd0);
        if (f && req_0) n_forced++;
        if (eg1) n_gnt1++;
        if (gnt_1z) z_gnt1++;
        if (forced_1z) z_forced++;
        if (eg0) begin
            if (we_0) ref_mem[addr_0[3:0]] = wdata_0;
            else begin it.port = 1'b0; it.data = ref_mem[addr_0[3:0]]; it.due = cyc + 2; exp_q.push_back(it); end
        end
        if (eg1) begin
            if (we_1) ref_mem[addr_1[3:0]] = wdata_1;
            else begin it.port = 1'b1; it.data = ref_mem[addr_1[3:0]]; it.due = cyc + 2; exp_q.push_back(it); end
        end
        if (!req_1 || eg1) ref_wait = 0;
        else if (ref_wait < 255) ref_wait++;
        g0 = eg0;
        g1 = eg1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // New random request on a port only once the previous one was accepted
    task automatic pick();
        if (!req_0 || g0) begin
            req_0   = ($urandom_range(0, 99) < 60);
            we_0    = 1'($urandom_range(0, 1));
            addr_0  = 32'($urandom_range(0, 15));
            wdata_0 = $urandom;
        end
        if (!req_1 || g1) begin
            req_1   = ($urandom_range(0, 99) < 50);
            we_1    = 1'($urandom_range(0, 1));
            addr_1  = 32'($urandom_range(0, 15));
            wdata_1 = $urandom;
        end
    endtask

    task automatic idle();
        req_0 = 1'b0;
        req_1 = 1'b0;
        we_0  = 1'b0;
        we_1  = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; ref_wait = 0;
        ref_rd0 = 32'd0; ref_rd1 = 32'd0; g0 = 1'b0; g1 = 1'b0;
        n_forced = 0; n_gnt1 = 0; z_gnt1 = 0; z_forced = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        addr_0 = 32'd0; addr_1 = 32'd0; wdata_0 = 32'd0; wdata_1 = 32'd0;
        req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b0; we_1 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_gnt_0", 64'(gnt_0), 64'd0);
        check_eq("rst_gnt_1", 64'(gnt_1), 64'd0);
        check_eq("rst_mem_read", 64'(mem_read), 64'd0);
        check_eq("rst_mem_write", 64'(mem_write), 64'd0);
        check_eq("rst_forced", 64'(forced_1), 64'd0);
        check_eq("rst_rvalid_0", 64'(rvalid_0), 64'd0);
        check_eq("rst_rvalid_1", 64'(rvalid_1), 64'd0);
        check_eq("rst_rdata_0", 64'(rdata_0), 64'd0);
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;

        // Port 0 read of word 3
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'd3;
        step();
        idle();
        step(); step();
        check_eq("t1_rdata_0", 64'(rdata_0), 64'h0000_00AB);

        // Both ports saturated: forced grant every fifth cycle, never with the guard disabled
        n_forced = 0; n_gnt1 = 0; z_gnt1 = 0; z_forced = 0;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'd1;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'd2;
        repeat (50) step();
        check_eq("t2_forced_cnt", 64'(n_forced), 64'd10);
        check_eq("t2_gnt1_cnt", 64'(n_gnt1), 64'd10);
        check_eq("t2_nowait_gnt1_cnt", 64'(z_gnt1), 64'd0);
        check_eq("t2_nowait_forced_cnt", 64'(z_forced), 64'd0);
        idle();
        step(); step();

        // Port 1 write then port 0 read of the same word
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 32'd5; wdata_1 = 32'hDEAD_BEEF;
        step();
        idle();
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'd5;
        step();
        idle();
        step(); step();
        check_eq("t4_rdata_0", 64'(rdata_0), 64'hDEAD_BEEF);

        // Alternating reads on consecutive cycles
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'd1;
        step();
        idle();
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'd2;
        step();
        idle();
        step(); step(); step();
        check_eq("t5_rdata_0", 64'(rdata_0), 64'(init_word(1)));
        check_eq("t5_rdata_1", 64'(rdata_1), 64'(init_word(2)));

        // Reset pulse between a read grant and its return
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'd7;
        step();
        rst_n = 1'b0;
        req_0 = 1'b1; req_1 = 1'b1;
        #2;
        check_eq("t6_gnt_0", 64'(gnt_0), 64'd0);
        check_eq("t6_gnt_1", 64'(gnt_1), 64'd0);
        check_eq("t6_mem_read", 64'(mem_read), 64'd0);
        check_eq("t6_forced", 64'(forced_1), 64'd0);
        check_eq("t6_rvalid_0", 64'(rvalid_0), 64'd0);
        check_eq("t6_rdata_0", 64'(rdata_0), 64'd0);
        #3;
        rst_n = 1'b1;
        idle();
        exp_q.delete();
        ref_wait = 0; ref_rd0 = 32'd0; ref_rd1 = 32'd0; g0 = 1'b0; g1 = 1'b0;
        cyc++;
        @(posedge clk);
        #1;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'd9;
        step();
        idle();
        step(); step();
        check_eq("t6_after_rdata_0", 64'(rdata_0), 64'(init_word(9)));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            pick();
            step();
        end
        idle();
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port, synchronous-read data memory.
- Port 0 is the CPU load/store path. Port 1 is the debug/loader path, used for preloading and inspecting data memory.
- Port 0 has fixed priority. A starvation guard forces a port 1 grant after a bounded wait.
- The block sits between the requesters and the data memory (mem_read, mem_write, address, write_data, read_data). The memory returns read data one clock after mem_read.

Parameters:
- ADDR_W, 32, address width of both ports and of the memory side.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive cycles port 1 may be denied before it is forced ahead of port 0. Legal range 0..255; 0 disables the guard (pure fixed priority).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_0  in  1  port 0 request.
- we_0  in  1  port 0 write (1) / read (0).
- addr_0  in  ADDR_W  port 0 address.
- wdata_0  in  DATA_W  port 0 write data.
- gnt_0  out  1  port 0 request accepted this cycle.
- rvalid_0  out  1  port 0 read data valid.
- rdata_0  out  DATA_W  port 0 read data.
- req_1, we_1, addr_1, wdata_1, gnt_1, rvalid_1, rdata_1  same as port 0, for port 1.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_read.
- forced_1  out  1  pulses in any cycle where port 1 wins over a concurrent port 0 request by starvation override.

Behaviour:
- Reset, asynchronous on rst_n low:
  - wait_cnt=0, rvalid_0=rvalid_1=0, rdata_0=rdata_1=0, pending-read owner cleared.
  - gnt_0, gnt_1, mem_read, mem_write and forced_1 are held at 0 while rst_n is low.
  - An in-flight read at reset is dropped; no rvalid follows reset release.
- Handshake:
  - A transfer occurs in a cycle where req_x=1 and gnt_x=1.
  - The requester holds req/we/addr/wdata stable until granted.
  - Grant is combinational from the current inputs and wait_cnt. At most one gnt per cycle.
  - Back-to-back transfers, one per cycle, are supported on either port.
- Arbitration, evaluated each cycle:
  - force = (MAX_WAIT!=0) and (wait_cnt >= MAX_WAIT) and req_1.
  - If force: gnt_1=1, gnt_0=0; forced_1=1 if req_0 is also asserted.
  - Else if req_0: gnt_0=1.
  - Else if req_1: gnt_1=1.
  - Else: no grant; mem_read=mem_write=0.
- Memory drive in the grant cycle, from the winner:
  - mem_addr=addr_x, mem_wdata=wdata_x, mem_write=we_x, mem_read=~we_x.
  - When idle, mem_addr and mem_wdata hold the port 0 inputs (don't-care). Strobes are 0.
- Read return:
  - On a read grant, the owner is registered.
  - Next cycle: rvalid_owner=1 and rdata_owner=mem_rdata, registered at the following edge, so latency is 2 cycles from grant to rvalid.
  - The rdata of the other port holds its previous value.
  - Writes produce no rvalid.
- wait_cnt, 8-bit, updated at the clock edge:
  - Cleared when gnt_1=1 or req_1=0.
  - Incremented (saturating at 255) when req_1=1 and gnt_1=0.
- Simultaneous events:
  - A port 0 write and a port 1 read to the same address in the same cycle are serialised by priority.
  - Port 1 reads the value after port 0's write.
- Pipelined reads: a read grant while a previous rvalid is outstanding is legal. The owner register is a 1-deep pipeline, so rvalids return in grant order, one per cycle.
- With MAX_WAIT=0, port 1 can starve indefinitely. This is intended for bring-up with the CPU halted.

Test Plan:
- Reset, then port 0 read addr 3 with memory word 3 = 0x0000_00AB: gnt_0 at cycle 0, mem_read=1, mem_addr=3; rvalid_0=1 and rdata_0=0xAB two edges later; rvalid_1 stays 0.
- req_0 and req_1 held high continuously, MAX_WAIT=4: gnt_0 for 4 cycles, then gnt_1 with forced_1=1 in cycle 5, wait_cnt→0; pattern repeats every 5 cycles.
- Same as above with MAX_WAIT=0: gnt_1 never asserts over 50 cycles; forced_1 stays 0.
- Port 1 writes 0xDEAD_BEEF to addr 5, then port 0 reads addr 5 next cycle: mem_write=1, mem_read=0 in the write cycle; rdata_0=0xDEADBEEF; no rvalid_1.
- Alternating reads: port 0 addr 1 then port 1 addr 2 on consecutive cycles: rvalid_0 then rvalid_1 on consecutive cycles with the correct data, no overlap.
- rst_n pulsed low for a half cycle between a read grant and its return: rvalid stays 0, all outputs 0, wait_cnt=0; the next request completes normally.
